// File: rtl/spi_temp_ctrl_if.sv
// Bus bundle for the SPI temperature sequencer.
// slave = sequencer side, master = requester/sensor side.
`timescale 1ns/1ps
interface spi_temp_ctrl_if #(
  parameter int DIV_W      = 8,
  parameter int FRAME_BITS = 16
);
  logic [DIV_W-1:0]      div_i;
  logic                  start_i;
  logic                  miso_i;
  logic                  sck_o;
  logic                  cs_n_o;
  logic                  busy_o;
  logic                  done_o;
  logic [FRAME_BITS-1:0] data_o;

  modport master (
    output div_i,
    output start_i,
    output miso_i,
    input  sck_o,
    input  cs_n_o,
    input  busy_o,
    input  done_o,
    input  data_o
  );

  modport slave (
    input  div_i,
    input  start_i,
    input  miso_i,
    output sck_o,
    output cs_n_o,
    output busy_o,
    output done_o,
    output data_o
  );
endinterface

// File: rtl/spi_temp_ctrl.sv
// SPI mode-0 read sequencer: one FRAME_BITS sample per start, MSB first.
// Ports: clk_in, rst_n (async low), bus (div/start/miso in; sck/cs_n/busy/done/data out).
`timescale 1ns/1ps
module spi_temp_ctrl #(
  parameter int DIV_W      = 8,
  parameter int FRAME_BITS = 16,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  spi_temp_ctrl_if.slave   bus
);

  localparam int BIT_W  = $clog2(FRAME_BITS + 1);
  localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DIV_W-1:0]      div_q;
  logic [DIV_W-1:0]      cnt_q;
  logic [PH_W-1:0]       ph_q;
  logic [BIT_W-1:0]      bit_q;
  logic                  sck_q;
  logic [FRAME_BITS-1:0] sh_q;
  logic [FRAME_BITS-1:0] data_q;

  logic active;
  logic tick;
  logic start_acc;
  logic setup_end;
  logic xfer_end;
  logic hold_end;

  assign active    = (state_q == SETUP) ||
                     (state_q == XFER)  ||
                     (state_q == HOLD);
  assign tick      = active && (cnt_q == div_q);
  assign start_acc = (state_q == IDLE) && bus.start_i;
  assign setup_end = tick && (ph_q == PH_W'(CS_SETUP - 1));
  assign hold_end  = tick && (ph_q == PH_W'(CS_HOLD - 1));
  // last falling SCK edge: all bits in and sck currently high
  assign xfer_end  = tick && sck_q &&
                     (bit_q == BIT_W'(FRAME_BITS));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.start_i) state_d = SETUP;
      SETUP: if (setup_end)   state_d = XFER;
      XFER:  if (xfer_end)    state_d = HOLD;
      HOLD:  if (hold_end)    state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      cnt_q  <= '0;
      ph_q   <= '0;
      bit_q  <= '0;
      sck_q  <= 1'b0;
      sh_q   <= '0;
      data_q <= '0;
    end else if (start_acc) begin
      div_q <= bus.div_i;
      cnt_q <= '0;
      ph_q  <= '0;
      bit_q <= '0;
      sck_q <= 1'b0;
      sh_q  <= '0;
    end else if (active) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      unique case (1'b1)
        (state_q == SETUP): begin
          if (tick) ph_q <= setup_end ? '0 : ph_q + 1'b1;
        end
        (state_q == XFER): begin
          if (tick) begin
            sck_q <= ~sck_q;
            // rising edge: sample miso at the same clk edge
            if (!sck_q) begin
              sh_q  <= {sh_q[FRAME_BITS-2:0], bus.miso_i};
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        (state_q == HOLD): begin
          if (tick) ph_q <= ph_q + 1'b1;
          // publish only a complete frame
          if (hold_end) data_q <= sh_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.sck_o  = sck_q;
  assign bus.cs_n_o = ~active;
  assign bus.busy_o = active;
  assign bus.done_o = (state_q == DONE);
  assign bus.data_o = data_q;

endmodule

// File: tb/tb_spi_temp_ctrl.sv
// Self-checking bench for spi_temp_ctrl with a mode-0 sensor model.
// Table-driven reads plus hand sequences for busy/back-to-back/reset cases.
`timescale 1ns/1ps
module tb_spi_temp_ctrl;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  spi_temp_ctrl_if bus ();

  spi_temp_ctrl dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // monitor state (written only by the monitor block)
  int cyc    = 0;
  int rises  = 0;
  int dones  = 0;
  int ph_bad = 0;
  int edge_c = 0;
  bit fall_v = 0;
  logic prev_sck_m = 1'b0;

  // sensor pattern feed
  logic [15:0] pats [0:31];
  int np = 0;
  int sp = 0;
  int bi = 0;
  logic [15:0] cur = '0;
  logic prev_cs_s = 1'b1;
  logic prev_sck_s = 1'b0;

  int exp_ph = 1;

  always @(posedge clk_in) begin
    cyc = cyc + 1;
    if (bus.done_o) dones = dones + 1;
    if (!prev_sck_m && bus.sck_o && !bus.cs_n_o) begin
      rises = rises + 1;
      if (fall_v && (cyc - edge_c != exp_ph)) ph_bad = ph_bad + 1;
      edge_c = cyc;
    end else if (prev_sck_m && !bus.sck_o && !bus.cs_n_o) begin
      if (cyc - edge_c != exp_ph) ph_bad = ph_bad + 1;
      edge_c = cyc;
      fall_v = 1;
    end
    if (bus.cs_n_o) fall_v = 0;
    prev_sck_m = bus.sck_o;
  end

  // sensor: MSB on cs_n fall, next bit after each SCK fall
  always @(negedge clk_in) begin
    if (prev_cs_s && !bus.cs_n_o) begin
      cur = pats[sp];
      sp = sp + 1;
      bi = 15;
      bus.miso_i = cur[15];
    end else if (prev_sck_s && !bus.sck_o && !bus.cs_n_o) begin
      if (bi > 0) bi = bi - 1;
      bus.miso_i = cur[bi];
    end
    prev_cs_s = bus.cs_n_o;
    prev_sck_s = bus.sck_o;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int lim);
    bit seen = 0;
    for (int t = 0; t < lim; t++) begin
      if (bus.done_o) begin
        seen = 1;
        break;
      end
      @(negedge clk_in);
    end
    chk({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic run_read(input logic [7:0] dv, input logic [15:0] pat,
                          input int lat, input string tag);
    int c0, r0, d0, pb0;
    pats[np] = pat;
    np = np + 1;
    exp_ph = int'(dv) + 1;
    r0 = rises; d0 = dones; pb0 = ph_bad;
    @(negedge clk_in);
    bus.div_i = dv;
    bus.start_i = 1'b1;
    @(negedge clk_in);
    c0 = cyc;
    bus.start_i = 1'b0;
    bus.div_i = ~dv;
    chk({tag, "_cs_low"}, bus.cs_n_o, 0);
    chk({tag, "_busy"}, bus.busy_o, 1);
    wait_done(tag, lat + 50);
    chk({tag, "_latency"}, cyc - c0, lat);
    chk({tag, "_data"}, bus.data_o, pat);
    chk({tag, "_cs_done"}, bus.cs_n_o, 1);
    chk({tag, "_busy_done"}, bus.busy_o, 0);
    @(negedge clk_in);
    chk({tag, "_pulse"}, bus.done_o, 0);
    chk({tag, "_hold"}, bus.data_o, pat);
    chk({tag, "_rises"}, rises - r0, 16);
    chk({tag, "_ndone"}, dones - d0, 1);
    chk({tag, "_phase"}, ph_bad - pb0, 0);
    bus.div_i = dv;
  endtask

  typedef struct {
    logic [7:0]  dv;
    logic [15:0] pat;
    int          lat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int c0, d0, r0;
    vecs[0] = '{8'd0,   16'hA5C3, 36};
    vecs[1] = '{8'd3,   16'h0FF0, 144};
    vecs[2] = '{8'd1,   16'h1234, 72};
    vecs[3] = '{8'd7,   16'h8001, 288};
    vecs[4] = '{8'd0,   16'h0000, 36};
    vecs[5] = '{8'd255, 16'h6B9D, 9216};
    vecs[6] = '{8'd0,   16'hFFFF, 36};

    bus.div_i = '0;
    bus.start_i = 1'b1;
    bus.miso_i = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk_in);
    chk("rst_sck", bus.sck_o, 0);
    chk("rst_cs", bus.cs_n_o, 1);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_data", bus.data_o, 0);
    chk("rst_rises", rises, 0);
    bus.start_i = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("idle_cs", bus.cs_n_o, 1);

    for (int i = 0; i < 7; i++) begin
      run_read(vecs[i].dv, vecs[i].pat, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // start pulses while busy are ignored
    pats[np] = 16'h3C5A;
    np = np + 1;
    exp_ph = 1;
    d0 = dones;
    @(negedge clk_in);
    bus.div_i = 8'd0;
    bus.start_i = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk_in);
      bus.start_i = (t == 4 || t == 19) ? 1'b1 : 1'b0;
    end
    bus.start_i = 1'b0;
    chk("busy_ndone", dones - d0, 1);
    chk("busy_idle", bus.busy_o, 0);
    chk("busy_data", bus.data_o, 16'h3C5A);

    // back-to-back with start held high
    pats[np] = 16'h1234;
    pats[np+1] = 16'hFFFF;
    np = np + 2;
    d0 = dones;
    @(negedge clk_in);
    bus.start_i = 1'b1;
    @(negedge clk_in);
    c0 = cyc;
    wait_done("b2b1", 100);
    chk("b2b1_lat", cyc - c0, 36);
    chk("b2b1_data", bus.data_o, 16'h1234);
    @(negedge clk_in);
    chk("b2b_gap_cs", bus.cs_n_o, 1);
    @(negedge clk_in);
    chk("b2b_restart_cs", bus.cs_n_o, 0);
    bus.start_i = 1'b0;
    wait_done("b2b2", 100);
    chk("b2b2_lat", cyc - c0, 74);
    chk("b2b2_data", bus.data_o, 16'hFFFF);
    @(negedge clk_in);
    chk("b2b_ndone", dones - d0, 2);

    // reset during XFER after 7 bits
    pats[np] = 16'hBEEF;
    np = np + 1;
    exp_ph = 2;
    r0 = rises;
    @(negedge clk_in);
    bus.div_i = 8'd1;
    bus.start_i = 1'b1;
    @(negedge clk_in);
    bus.start_i = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (rises - r0 >= 7) break;
      @(negedge clk_in);
    end
    chk("mid_bits", rises - r0, 7);
    d0 = dones;
    rst_n = 1'b0;
    #1;
    chk("mid_cs", bus.cs_n_o, 1);
    chk("mid_sck", bus.sck_o, 0);
    chk("mid_busy", bus.busy_o, 0);
    chk("mid_data", bus.data_o, 0);
    repeat (10) @(negedge clk_in);
    chk("mid_nodone", dones - d0, 0);
    rst_n = 1'b1;
    @(negedge clk_in);
    run_read(8'd0, 16'h8001, 36, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_temp_ctrl.md
Name: spi_temp_ctrl

Overview:
SPI read sequencer for the temperature sensor, built around an internal programmable prescaler that derives SCK from clk_in. On a start request it asserts chip-select, clocks in one FRAME_BITS-wide sample in SPI mode 0, MSB first, and releases chip-select. It then presents the sample with a one-cycle done pulse. It sits between the system clock domain and the sensor pins; downstream logic consumes data_o on done_o.

Parameters:
DIV_W, 8, width of the prescaler divide setting
FRAME_BITS, 16, bits per sensor read frame
CS_SETUP, 2, prescaler ticks from cs_n falling to the first SCK rising edge
CS_HOLD, 2, prescaler ticks from the last SCK falling edge to cs_n rising

Ports:
clk_in  in  1  system clock, all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
div_i  in  DIV_W  SCK half-period minus 1, in clk_in cycles
start_i  in  1  read request, level-sampled
miso_i  in  1  sensor serial data
sck_o  out  1  SPI clock, idle low
cs_n_o  out  1  sensor chip-select, active low
busy_o  out  1  high while a transfer is in progress
done_o  out  1  one-cycle pulse when data_o updates
data_o  out  FRAME_BITS  last captured sample

Behaviour:
- Reset (async, rst_n=0): state IDLE; sck_o=0, cs_n_o=1, busy_o=0, done_o=0, data_o=0; prescaler counter, bit counter and shift register cleared. Takes effect immediately, including mid-transfer. No partial data reaches data_o.
- Prescaler: counter cnt runs only outside IDLE/DONE. tick=1 when cnt==div_q, then cnt wraps to 0; otherwise cnt increments. Tick period is div_q+1 cycles. div_i=0 gives a tick every cycle (SCK = clk_in/2).
- div_i is latched into div_q only when a start is accepted. Later changes have no effect until the next transfer.
- States: IDLE, SETUP, XFER, HOLD, DONE.
- IDLE: start_i=1 at a rising edge latches div_i, clears cnt, and enters SETUP. cs_n_o=0 and busy_o=1 from that edge.
- SETUP: after CS_SETUP ticks, enter XFER. sck_o stays 0.
- XFER: each tick toggles sck_o.
  - On a 0->1 toggle, miso_i is sampled at the same clk_in edge and shifted into the shift register LSB (shift left). The bit counter increments.
  - After 2*FRAME_BITS ticks (FRAME_BITS rising edges, sck_o back to 0), enter HOLD.
- HOLD: after CS_HOLD ticks, enter DONE.
- DONE (exactly one cycle): cs_n_o=1, busy_o=0, done_o=1, data_o=shift register. Next state is IDLE.
- start_i is ignored in SETUP, XFER, HOLD and DONE. It is honoured only in IDLE, so a held-high start_i restarts one cycle after the DONE cycle.
- Latency: start accepted at edge E0 gives done_o high in the cycle after edge E0 + N*(div_q+1), where N = CS_SETUP + 2*FRAME_BITS + CS_HOLD. Defaults give N=36.
- SCK timing: high and low phases are each div_q+1 cycles. cs_n_o falls one tick period plus (CS_SETUP-1)*(div_q+1) cycles before the first SCK rising edge.
- data_o holds its value between done pulses.

Test Plan:
- Reset check: assert rst_n=0 with start_i=1 -> sck_o=0, cs_n_o=1, busy_o=0, done_o=0, data_o=0; no activity until release.
- Basic read: div_i=0, sensor model drives 0xA5C3 MSB first (changes on SCK falling) -> 16 SCK rising edges, done_o pulses exactly 36 cycles after start accept, data_o=0xA5C3, cs_n_o high in the done cycle.
- Divided clock: div_i=3, pattern 0x0FF0 -> SCK high/low phases each 4 cycles, done at 144 cycles, data_o=0x0FF0. Changing div_i to 0 mid-transfer leaves the timing unchanged.
- Start while busy: pulse start_i at cycles 5 and 20 of a transfer -> exactly one transfer; a single done_o pulse.
- Back-to-back: hold start_i=1 with patterns 0x1234 then 0xFFFF -> second cs_n_o fall one cycle after the first DONE cycle; data_o=0x1234 then 0xFFFF.
- Reset mid-transfer: drop rst_n during XFER after 7 bits -> cs_n_o=1 and sck_o=0 immediately, data_o=0, no done_o. A subsequent read of 0x8001 completes correctly.
